fb_memory_arbiter: RTL and testbench
====================================

// Module: fb_memory_arbiter
// PURPOSE
//  Shares a single Avalon-MM memory port between the video pixel DMA (read-only, real-time) and a CPU
//  data master (read/write). Video has priority, and a starvation bound guarantees CPU progress.
//  A tag FIFO of outstanding reads steers each pipelined readdatavalid back to the requester that issued it.
//  Sits in the memory_clock domain between the video DMA, the CPU, and the SDRAM controller.
// PARAMETERS
//  PENDING_LG2     2   log2 of max outstanding reads (tag FIFO depth = 2**PENDING_LG2 = 4)
//  CPU_STARVE_MAX  8   consecutive accepted video commands while CPU waits before CPU is forced a grant
// PORTS
//  memory_clock       in   1   sole clock
//  reset_n            in   1   synchronous, active-low reset
//  vid_address        in   30  video DMA word address
//  vid_read           in   1   video read request
//  vid_waitrequest    out  1   video stall
//  vid_readdata       out  32  = mem_readdata
//  vid_readdatavalid  out  1   read data valid for video
//  cpu_address        in   30  CPU address
//  cpu_read           in   1   CPU read request
//  cpu_write          in   1   CPU write request (never together with cpu_read)
//  cpu_writedata      in   32  CPU write data
//  cpu_byteenable     in   4   CPU byte enables
//  cpu_waitrequest    out  1   CPU stall
//  cpu_readdata       out  32  = mem_readdata
//  cpu_readdatavalid  out  1   read data valid for CPU
//  mem_address        out  30  address to memory
//  mem_read           out  1   read to memory
//  mem_write          out  1   write to memory
//  mem_writedata      out  32  write data
//  mem_byteenable     out  4   byte enables (4'hF for video)
//  mem_waitrequest    in   1   memory stall
//  mem_readdata       in   32  memory read data
//  mem_readdatavalid  in   1   memory read data valid, in order
//  err_orphan         out  1   sticky: readdatavalid arrived with no read outstanding
// BEHAVIOUR
//  - Reset (reset_n=0 at clock edge): owner=NONE, lock=0, starve_cnt=0, tag FIFO emptied, err_orphan=0.
//    While reset_n=0: mem_read=mem_write=0, both waitrequests=1, both readdatavalids=0.
//  - Command path is combinational, with 0-cycle latency: the selected master's address, data and controls
//    are driven to mem_*. The unselected master sees waitrequest=1. Accept = selected request & !mem_waitrequest.
//  - Selection when lock=0:
//    - CPU if cpu requests and (no vid_read or starve_cnt==CPU_STARVE_MAX);
//    - else video if vid_read;
//    - else none.
//    When lock=1, the registered owner is kept.
//  - Lock: set at an edge where the selected request is presented with mem_waitrequest=1, and owner is
//    registered. Cleared on accept. This keeps the Avalon request stable until it is accepted.
//  - starve_cnt:
//    - +1 on each accepted video command while a CPU request is pending, saturating at CPU_STARVE_MAX;
//    - 0 on CPU accept, or on any cycle with no CPU request.
//  - Tag FIFO (circular, 2**PENDING_LG2 entries, count width PENDING_LG2+1):
//    - push owner bit (1=CPU) on each accepted read; pop on mem_readdatavalid;
//    - push and pop in the same cycle leave count unchanged.
//  - FIFO full (count==2**PENDING_LG2): reads are not forwarded (mem_read=0, requester waitrequest=1),
//    even if a pop occurs in that cycle. Writes are unaffected. Full with a CPU read pending and no video
//    request: no grant.
//  - Full while locked on a read is impossible, because lock only arises with a read already presented.
//  - Response routing (combinational): the head tag selects vid_ or cpu_readdatavalid.
//    mem_readdatavalid with count==0: dropped, err_orphan<=1, count stays 0.
//  - Reset mid-transfer discards outstanding tags. Late responses are then dropped and flagged as orphans;
//    the integrator must quiesce memory before asserting reset.
// CONFIGURATION
//  - FB_ARB_STATS_EN defined: adds outputs stat_vid_grants[31:0], stat_cpu_grants[31:0], stat_full_stalls[31:0].
//    - stat_vid_grants and stat_cpu_grants count accepted commands.
//    - stat_full_stalls counts cycles in which a read was blocked by a full FIFO.
//    - All are 0 on reset and wrap modulo 2**32.
//  - FB_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. vid_read and cpu_write held high, mem_waitrequest=0 -> 8 video accepts, then 1 CPU accept, then video
//     again; starve_cnt returns to 0.
//  2. cpu_read presented, mem_waitrequest=1 for 3 cycles, vid_read rises during the stall -> CPU stays granted;
//     mem_address is stable for all 4 cycles; video is accepted afterwards.
//  3. 4 video reads accepted, no responses -> 5th read blocked (vid_waitrequest=1, mem_read=0); a CPU write
//     in that window is accepted; the first readdatavalid releases the 5th read on the next cycle.
//  4. Interleaved V,C,V reads, responses 0xA,0xB,0xC -> vid_readdatavalid gets A and C, cpu_readdatavalid gets B.
//  5. mem_readdatavalid pulse with nothing outstanding -> no readdatavalid on either master; err_orphan=1
//     until reset_n=0.
//  6. reset_n=0 with 2 reads outstanding -> waitrequests=1, count=0; a post-reset response sets err_orphan.

Source files
------------

// File: rtl/fb_memory_arbiter.sv
// Shares one Avalon-MM memory port between a real-time video read DMA and a CPU data master.
// Defining FB_ARB_STATS_EN adds grant and full-stall statistics counters.
module fb_memory_arbiter #(
    parameter int PENDING_LG2    = 2,
    parameter int CPU_STARVE_MAX = 8
) (
    input  logic        memory_clock,
    input  logic        reset_n,
    input  logic [29:0] vid_address,
    input  logic        vid_read,
    output logic        vid_waitrequest,
    output logic [31:0] vid_readdata,
    output logic        vid_readdatavalid,
    input  logic [29:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    input  logic [3:0]  cpu_byteenable,
    output logic        cpu_waitrequest,
    output logic [31:0] cpu_readdata,
    output logic        cpu_readdatavalid,
    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid,
    output logic        err_orphan
`ifdef FB_ARB_STATS_EN
    ,
    output logic [31:0] stat_vid_grants,
    output logic [31:0] stat_cpu_grants,
    output logic [31:0] stat_full_stalls
`endif
);

    localparam int DEPTH = 1 << PENDING_LG2;
    localparam int SW    = $clog2(CPU_STARVE_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    owner_e                 owner_q, owner_d, sel_s;
    logic                   lock_q, lock_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic [DEPTH-1:0]       tag_q, tag_d;
    logic [PENDING_LG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PENDING_LG2:0]   count_q, count_d;
    logic                   err_orphan_q, err_orphan_d;

    logic full_s, empty_s, cpu_req_s, vid_ok_s, cpu_ok_s, starve_sat_s;
    logic present_rd_s, present_wr_s, accept_s, vid_acc_s, cpu_acc_s;
    logic push_s, pop_s, head_s;

    assign full_s       = (count_q == (PENDING_LG2 + 1)'(DEPTH));
    assign empty_s      = (count_q == {(PENDING_LG2 + 1){1'b0}});
    assign cpu_req_s    = cpu_read | cpu_write;
    assign vid_ok_s     = vid_read & ~full_s;
    assign cpu_ok_s     = cpu_write | (cpu_read & ~full_s);
    assign starve_sat_s = (starve_q == SW'(CPU_STARVE_MAX));
    assign head_s       = tag_q[rptr_q];

    // Master selection: a stalled request keeps its owner, otherwise video wins unless the CPU is starved.
    always_comb begin
        sel_s = OWN_NONE;
        if (lock_q) begin
            sel_s = owner_q;
        end else if (cpu_ok_s && (!vid_ok_s || starve_sat_s)) begin
            sel_s = OWN_CPU;
        end else if (vid_ok_s) begin
            sel_s = OWN_VID;
        end else begin
            sel_s = OWN_NONE;
        end
    end

    // Command mux; reads are withheld while the tag FIFO is full, and nothing is issued in reset.
    always_comb begin
        present_rd_s   = 1'b0;
        present_wr_s   = 1'b0;
        mem_address    = vid_address;
        mem_byteenable = 4'hF;
        case (sel_s)
            OWN_VID: begin
                present_rd_s = vid_read & ~full_s;
            end
            OWN_CPU: begin
                present_rd_s   = cpu_read & ~full_s;
                present_wr_s   = cpu_write;
                mem_address    = cpu_address;
                mem_byteenable = cpu_byteenable;
            end
            default: begin
                present_rd_s = 1'b0;
                present_wr_s = 1'b0;
            end
        endcase
        mem_read        = reset_n & present_rd_s;
        mem_write       = reset_n & present_wr_s;
        accept_s        = (mem_read | mem_write) & ~mem_waitrequest;
        vid_acc_s       = accept_s & (sel_s == OWN_VID);
        cpu_acc_s       = accept_s & (sel_s == OWN_CPU);
        vid_waitrequest = ~vid_acc_s;
        cpu_waitrequest = ~cpu_acc_s;
    end

    assign mem_writedata     = cpu_writedata;
    assign vid_readdata      = mem_readdata;
    assign cpu_readdata      = mem_readdata;
    assign push_s            = mem_read & ~mem_waitrequest;
    assign pop_s             = reset_n & mem_readdatavalid & ~empty_s;
    assign vid_readdatavalid = pop_s & ~head_s;
    assign cpu_readdatavalid = pop_s & head_s;
    assign err_orphan        = err_orphan_q;

    // Next state for lock, starvation counter, tag FIFO and orphan flag.
    always_comb begin
        lock_d       = (mem_read | mem_write) & mem_waitrequest;
        owner_d      = lock_d ? sel_s : OWN_NONE;
        starve_d     = starve_q;
        tag_d        = tag_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        err_orphan_d = err_orphan_q | (mem_readdatavalid & empty_s);
        if (!cpu_req_s || cpu_acc_s) begin
            starve_d = {SW{1'b0}};
        end else if (vid_acc_s && !starve_sat_s) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
        if (push_s) begin
            tag_d[wptr_q] = (sel_s == OWN_CPU);
            wptr_d        = wptr_q + PENDING_LG2'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PENDING_LG2'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PENDING_LG2 + 1)'(1);
            2'b01:   count_d = count_q - (PENDING_LG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge memory_clock) begin
        if (!reset_n) begin
            owner_q      <= OWN_NONE;
            lock_q       <= 1'b0;
            starve_q     <= {SW{1'b0}};
            tag_q        <= {DEPTH{1'b0}};
            wptr_q       <= {PENDING_LG2{1'b0}};
            rptr_q       <= {PENDING_LG2{1'b0}};
            count_q      <= {(PENDING_LG2 + 1){1'b0}};
            err_orphan_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            lock_q       <= lock_d;
            starve_q     <= starve_d;
            tag_q        <= tag_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [31:0] stat_vid_q, stat_vid_d, stat_cpu_q, stat_cpu_d, stat_full_q, stat_full_d;
    logic        full_block_s;

    assign full_block_s = reset_n & full_s & (vid_read | cpu_read);

    // Statistics increments, wrapping naturally at 2**32.
    always_comb begin
        stat_vid_d  = stat_vid_q + {31'd0, vid_acc_s};
        stat_cpu_d  = stat_cpu_q + {31'd0, cpu_acc_s};
        stat_full_d = stat_full_q + {31'd0, full_block_s};
    end

    // Statistics registers.
    always_ff @(posedge memory_clock) begin
        if (!reset_n) begin
            stat_vid_q  <= 32'd0;
            stat_cpu_q  <= 32'd0;
            stat_full_q <= 32'd0;
        end else begin
            stat_vid_q  <= stat_vid_d;
            stat_cpu_q  <= stat_cpu_d;
            stat_full_q <= stat_full_d;
        end
    end

    assign stat_vid_grants  = stat_vid_q;
    assign stat_cpu_grants  = stat_cpu_q;
    assign stat_full_stalls = stat_full_q;
`endif

endmodule

// File: tb/tb_fb_memory_arbiter.sv
// Self-checking bench for fb_memory_arbiter: directed vector table, hand sequences and
// randomized traffic compared against a queue-based reference model.
module tb_fb_memory_arbiter;

    logic        memory_clock = 1'b0;
    logic        reset_n;
    logic [29:0] vid_address;
    logic        vid_read;
    logic        vid_waitrequest;
    logic [31:0] vid_readdata;
    logic        vid_readdatavalid;
    logic [29:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic        err_orphan;
`ifdef FB_ARB_STATS_EN
    logic [31:0] stat_vid_grants, stat_cpu_grants, stat_full_stalls;
`endif

    always #5 memory_clock = ~memory_clock;

    fb_memory_arbiter #(.PENDING_LG2(2), .CPU_STARVE_MAX(8)) dut (
        .memory_clock(memory_clock), .reset_n(reset_n),
        .vid_address(vid_address), .vid_read(vid_read), .vid_waitrequest(vid_waitrequest),
        .vid_readdata(vid_readdata), .vid_readdatavalid(vid_readdatavalid),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
        .cpu_readdatavalid(cpu_readdatavalid),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .err_orphan(err_orphan)
`ifdef FB_ARB_STATS_EN
        , .stat_vid_grants(stat_vid_grants), .stat_cpu_grants(stat_cpu_grants),
        .stat_full_stalls(stat_full_stalls)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: outstanding reads as a queue of "is CPU" flags.
    bit m_q[$];
    int m_starve = 0;
    bit m_lock   = 1'b0;
    int m_owner  = 0;
    bit m_err    = 1'b0;

    int e_sel;
    bit e_rd, e_wr, e_acc, e_vwt, e_cwt, e_vv, e_cv;

    typedef struct {
        logic rst_n, vr, cr, cw, mw, rdv;
        logic mr, mwr, vw, cwt, vv, cv, err;
        logic [1:0] asel;
    } vec_t;

    vec_t tbl [23];

    task automatic chk1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit full, vid_ok, cpu_ok;
        full   = (m_q.size() == 4);
        vid_ok = vid_read && !full;
        cpu_ok = cpu_write || (cpu_read && !full);
        if (m_lock) e_sel = m_owner;
        else if (cpu_ok && (!vid_ok || m_starve == 8)) e_sel = 2;
        else if (vid_ok) e_sel = 1;
        else e_sel = 0;
        e_rd  = reset_n && !full && ((e_sel == 1 && vid_read) || (e_sel == 2 && cpu_read));
        e_wr  = reset_n && e_sel == 2 && cpu_write;
        e_acc = (e_rd || e_wr) && !mem_waitrequest;
        e_vwt = !(e_acc && e_sel == 1);
        e_cwt = !(e_acc && e_sel == 2);
        e_vv  = reset_n && mem_readdatavalid && m_q.size() > 0 && m_q[0] == 1'b0;
        e_cv  = reset_n && mem_readdatavalid && m_q.size() > 0 && m_q[0] == 1'b1;
    endtask

    task automatic model_commit();
        if (!reset_n) begin
            m_q.delete();
            m_starve = 0;
            m_lock   = 1'b0;
            m_owner  = 0;
            m_err    = 1'b0;
        end else begin
            m_lock  = (e_rd || e_wr) && mem_waitrequest;
            m_owner = m_lock ? e_sel : 0;
            if (!(cpu_read || cpu_write) || (e_acc && e_sel == 2)) m_starve = 0;
            else if (e_acc && e_sel == 1 && m_starve < 8) m_starve++;
            if (mem_readdatavalid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (e_rd && e_acc) m_q.push_back(e_sel == 2);
        end
    endtask

    task automatic tick_pre();
        #1;
        model_eval();
        chk1("mem_read", mem_read, e_rd);
        chk1("mem_write", mem_write, e_wr);
        chk1("vid_waitrequest", vid_waitrequest, e_vwt);
        chk1("cpu_waitrequest", cpu_waitrequest, e_cwt);
        chk1("vid_readdatavalid", vid_readdatavalid, e_vv);
        chk1("cpu_readdatavalid", cpu_readdatavalid, e_cv);
        chk1("err_orphan", err_orphan, m_err);
        if (e_rd || e_wr) begin
            chkw("mem_address", 32'(mem_address), (e_sel == 2) ? 32'(cpu_address) : 32'(vid_address));
            chkw("mem_byteenable", 32'(mem_byteenable), (e_sel == 2) ? 32'(cpu_byteenable) : 32'hF);
        end
        if (e_wr) chkw("mem_writedata", mem_writedata, cpu_writedata);
        if (e_vv) chkw("vid_readdata", vid_readdata, mem_readdata);
        if (e_cv) chkw("cpu_readdata", cpu_readdata, mem_readdata);
    endtask

    task automatic tick_post();
        model_commit();
        @(posedge memory_clock);
        @(negedge memory_clock);
    endtask

    initial begin
        bit vid_done, cpu_done;
        int op;

        // rst_n vr cr cw mw rdv | mr mwr vw cwt vv cv err asel
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd2};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd2};
        tbl[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd2};
        tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd2};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd1};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,2'd0};
        tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0};
        tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,2'd0};
        for (int i = 10; i < 14; i++)
            tbl[i] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'd1};
        tbl[14] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,2'd2};
        tbl[15] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,2'd0};
        tbl[16] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'd1};
        tbl[17] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,2'd0};
        tbl[18] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,2'd0};
        tbl[19] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'd2};
        tbl[20] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,2'd0};
        tbl[21] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0};
        tbl[22] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,2'd0};

        reset_n = 1'b0; vid_read = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        vid_address = 30'h111; cpu_address = 30'h222; cpu_writedata = 32'd0;
        cpu_byteenable = 4'h5; mem_waitrequest = 1'b0; mem_readdata = 32'd0;
        mem_readdatavalid = 1'b0;
        @(posedge memory_clock);
        @(negedge memory_clock);

        // Directed vector table: lock during stall, routing, orphan, full FIFO, reset.
        for (int i = 0; i < 23; i++) begin
            reset_n = tbl[i].rst_n; vid_read = tbl[i].vr; cpu_read = tbl[i].cr;
            cpu_write = tbl[i].cw; mem_waitrequest = tbl[i].mw; mem_readdatavalid = tbl[i].rdv;
            cpu_writedata = 32'hDEAD_0000 + 32'(i); mem_readdata = 32'h0000_00A0 + 32'(i);
            tick_pre();
            chk1($sformatf("tbl%0d_mem_read", i), mem_read, tbl[i].mr);
            chk1($sformatf("tbl%0d_mem_write", i), mem_write, tbl[i].mwr);
            chk1($sformatf("tbl%0d_vid_wait", i), vid_waitrequest, tbl[i].vw);
            chk1($sformatf("tbl%0d_cpu_wait", i), cpu_waitrequest, tbl[i].cwt);
            chk1($sformatf("tbl%0d_vid_rdv", i), vid_readdatavalid, tbl[i].vv);
            chk1($sformatf("tbl%0d_cpu_rdv", i), cpu_readdatavalid, tbl[i].cv);
            chk1($sformatf("tbl%0d_err_orphan", i), err_orphan, tbl[i].err);
            if (tbl[i].asel == 2'd1) chkw($sformatf("tbl%0d_addr", i), 32'(mem_address), 32'h111);
            if (tbl[i].asel == 2'd2) chkw($sformatf("tbl%0d_addr", i), 32'(mem_address), 32'h222);
            tick_post();
        end

        // Starvation bound: video and CPU write held high, video reads answered next cycle.
        reset_n = 1'b0; vid_read = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0;
        tick_pre(); tick_post();
        reset_n = 1'b1;
        for (int k = 0; k < 19; k++) begin
            vid_read = (k < 18); cpu_write = (k < 18);
            mem_readdatavalid = (k > 0) && (k - 1 != 8) && (k - 1 != 17);
            mem_readdata = 32'h5000 + 32'(k);
            tick_pre();
            if (k < 18) begin
                chk1($sformatf("starve_vid_grant_%0d", k), !vid_waitrequest, !(k == 8 || k == 17));
                chk1($sformatf("starve_cpu_grant_%0d", k), !cpu_waitrequest, (k == 8 || k == 17));
            end
            tick_post();
        end

        // Randomized traffic against the reference model.
        reset_n = 1'b0; vid_read = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        mem_readdatavalid = 1'b0;
        tick_pre(); tick_post();
        for (int n = 0; n < 3000; n++) begin
            vid_done = e_acc && e_sel == 1 && reset_n;
            cpu_done = e_acc && e_sel == 2 && reset_n;
            reset_n = ($urandom_range(0, 299) != 0);
            if (!vid_read || vid_done) begin
                vid_read = ($urandom_range(0, 1) == 1);
                vid_address = 30'($urandom());
            end
            if (!(cpu_read || cpu_write) || cpu_done) begin
                op = int'($urandom_range(0, 2));
                cpu_read = (op == 1);
                cpu_write = (op == 2);
                cpu_address = 30'($urandom());
                cpu_writedata = $urandom();
                cpu_byteenable = 4'($urandom());
            end
            mem_waitrequest = ($urandom_range(0, 2) == 0);
            mem_readdatavalid = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
            mem_readdata = $urandom();
            tick_pre();
            tick_post();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
